// File: rtl/perm_ctrl_pkg.sv
// Shared constants and FSM state types for the permutation frame controller.
package perm_ctrl_pkg;

    localparam int BEATS_PER_FRAME_DEF = 32;
    localparam int BEAT_W = $clog2(BEATS_PER_FRAME_DEF);

    typedef enum logic [0:0] {
        I_IDLE = 1'b0,
        I_FILL = 1'b1
    } in_state_e;

    typedef enum logic [0:0] {
        O_IDLE  = 1'b0,
        O_BURST = 1'b1
    } out_state_e;

endpackage

// File: rtl/perm_beat_cnt.sv
// Wrapping beat counter: advances while en is high, wraps to zero after the last beat.
module perm_beat_cnt #(
    parameter int N = 32,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         start,
    output logic         last
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next-count computation with wrap at the final beat
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (last) begin
                cnt_d = {W{1'b0}};
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt   = cnt_q;
    assign last  = (cnt_q == W'(N - 1));
    // Beat 0 only occurs with en on the cycle a frame begins
    assign start = en && (cnt_q == {W{1'b0}});

endmodule

// File: rtl/perm_frame_ctrl.sv
// Frame controller for a non-stallable 1024-point permutation datapath:
// admits input frames, tracks frames in flight, and frames the output bursts.
module perm_frame_ctrl
    import perm_ctrl_pkg::*;
#(
    parameter int BEATS_PER_FRAME = BEATS_PER_FRAME_DEF,
    parameter int MAX_INFLIGHT    = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic                               in_sof,
    output logic                               in_ready,
    output logic [$clog2(BEATS_PER_FRAME)-1:0] in_beat,
    output logic                               perm_in_start,
    input  logic                               perm_out_start,
    output logic                               out_valid,
    output logic                               out_sof,
    output logic                               out_eof,
    output logic [$clog2(BEATS_PER_FRAME)-1:0] out_beat,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight,
    output logic                               err_gap,
    output logic                               err_spurious,
    output logic                               err_overlap,
    input  logic                               clear_err
);

    localparam int CW = $clog2(BEATS_PER_FRAME);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] MAX_IF = IW'(MAX_INFLIGHT);

    in_state_e      in_state_d, in_state_q;
    out_state_e     out_state_d, out_state_q;
    logic [IW-1:0]  inflight_d, inflight_q;
    logic           err_gap_d, err_gap_q;
    logic           err_spurious_d, err_spurious_q;
    logic           err_overlap_d, err_overlap_q;

    logic           accept_s, in_en_s, in_last_s, in_start_s;
    logic           out_go_s, out_en_s, out_last_s, out_start_s;
    logic           eof_s, gap_s, spurious_s, overlap_s;

    // Handshake, burst start and error detection for the current cycle
    always_comb begin
        in_ready   = 1'b0;
        accept_s   = 1'b0;
        gap_s      = 1'b0;
        out_go_s   = 1'b0;
        spurious_s = 1'b0;
        overlap_s  = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else begin
            if (in_state_q == I_IDLE) begin
                in_ready = (inflight_q < MAX_IF);
                accept_s = in_valid && in_sof && in_ready;
            end else begin
                in_ready = 1'b1;
                gap_s    = !in_valid;
            end
            if (out_state_q == O_IDLE) begin
                out_go_s   = perm_out_start && (inflight_q != {IW{1'b0}});
                spurious_s = perm_out_start && (inflight_q == {IW{1'b0}});
            end else begin
                overlap_s  = perm_out_start;
            end
        end
    end

    assign in_en_s  = accept_s || (!rst && (in_state_q == I_FILL));
    assign out_en_s = out_go_s || (!rst && (out_state_q == O_BURST));
    assign eof_s    = !rst && (out_state_q == O_BURST) && out_last_s;

    perm_beat_cnt #(.N(BEATS_PER_FRAME), .W(CW)) u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (in_en_s),
        .cnt   (in_beat),
        .start (in_start_s),
        .last  (in_last_s)
    );

    perm_beat_cnt #(.N(BEATS_PER_FRAME), .W(CW)) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (out_en_s),
        .cnt   (out_beat),
        .start (out_start_s),
        .last  (out_last_s)
    );

    // Next-state for both FSMs, the in-flight count and the sticky error flags
    always_comb begin
        in_state_d  = in_state_q;
        out_state_d = out_state_q;
        inflight_d  = inflight_q;
        case (in_state_q)
            I_IDLE:  in_state_d = accept_s ? I_FILL : I_IDLE;
            I_FILL:  in_state_d = in_last_s ? I_IDLE : I_FILL;
            default: in_state_d = I_IDLE;
        endcase
        case (out_state_q)
            O_IDLE:  out_state_d = out_go_s ? O_BURST : O_IDLE;
            O_BURST: out_state_d = out_last_s ? O_IDLE : O_BURST;
            default: out_state_d = O_IDLE;
        endcase
        case ({accept_s, eof_s})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
        // A fresh error wins over a simultaneous clear
        err_gap_d      = gap_s      || (err_gap_q      && !clear_err);
        err_spurious_d = spurious_s || (err_spurious_q && !clear_err);
        err_overlap_d  = overlap_s  || (err_overlap_q  && !clear_err);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q     <= I_IDLE;
            out_state_q    <= O_IDLE;
            inflight_q     <= {IW{1'b0}};
            err_gap_q      <= 1'b0;
            err_spurious_q <= 1'b0;
            err_overlap_q  <= 1'b0;
        end else begin
            in_state_q     <= in_state_d;
            out_state_q    <= out_state_d;
            inflight_q     <= inflight_d;
            err_gap_q      <= err_gap_d;
            err_spurious_q <= err_spurious_d;
            err_overlap_q  <= err_overlap_d;
        end
    end

    assign perm_in_start = in_start_s;
    assign out_valid     = out_en_s;
    assign out_sof       = out_start_s;
    assign out_eof       = eof_s;
    assign inflight      = inflight_q;
    assign err_gap       = err_gap_q;
    assign err_spurious  = err_spurious_q;
    assign err_overlap   = err_overlap_q;

endmodule
